// File: rtl/key_debounce_if.sv
// Bundled key-scanner interface: raw key levels and configuration in,
// debounced levels, event pulses and interrupt status out.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4,
  parameter int CNT_W    = 12
);
  logic [NUM_KEYS-1:0] col;
  logic [CNT_W-1:0]    db_thresh;
  logic [CNT_W-1:0]    rep_period;
  logic [1:0]          evt_mode;
  logic [NUM_KEYS-1:0] irq_mask;
  logic [NUM_KEYS-1:0] irq_clr;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;
  logic [NUM_KEYS-1:0] irq_pending;
  logic                irq;

  modport master (
    output col, db_thresh, rep_period, evt_mode, irq_mask, irq_clr,
    input  key_state, key_press, key_release, key_repeat, irq_pending, irq
  );

  modport slave (
    input  col, db_thresh, rep_period, evt_mode, irq_mask, irq_clr,
    output key_state, key_press, key_release, key_repeat, irq_pending, irq
  );
endinterface

// File: rtl/key_debounce_array.sv
// Per-channel key debouncer with auto-repeat and sticky interrupt flags.
//
// Repeat FSM (per channel):
//   state | meaning
//   IDLE  | debounced key released; repeat counter held at 0
//   HELD  | debounced key pressed; repeat counter runs while rep_period != 0
module key_debounce_array #(
  parameter int NUM_KEYS = 4,
  parameter int CNT_W    = 12
) (
  input logic           HCLK,
  input logic           HRESET,
  key_debounce_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } rep_state_t;

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [NUM_KEYS-1:0] key_state_v;
  logic [NUM_KEYS-1:0] press_v;
  logic [NUM_KEYS-1:0] release_v;
  logic [NUM_KEYS-1:0] repeat_v;
  logic [NUM_KEYS-1:0] pending_q;
  logic                irq_q;

  logic [CNT_W-1:0] thresh_eff;
  logic [CNT_W-1:0] thresh_m1;
  logic [CNT_W-1:0] rep_m1;

  // A zero threshold behaves as a single-cycle debounce.
  assign thresh_eff = (bus.db_thresh == '0) ? CNT_W'(1) : bus.db_thresh;
  assign thresh_m1  = thresh_eff - CNT_W'(1);
  assign rep_m1     = bus.rep_period - CNT_W'(1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.col;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] rep_cnt;
    rep_state_t       st;
    logic             state_q;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    logic             differ;
    logic             hit;

    assign differ = sync_q2[i] ^ state_q;
    // >= rather than == so a threshold lowered mid-count fires at once.
    assign hit    = differ && (db_cnt >= thresh_m1);

    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
        db_cnt    <= '0;
        rep_cnt   <= '0;
        st        <= IDLE;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;

        if (!differ) begin
          db_cnt <= '0;
        end else if (hit) begin
          db_cnt  <= '0;
          state_q <= ~state_q;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end

        case (st)
          IDLE: begin
            rep_cnt <= '0;
            if (hit && !state_q) begin
              st      <= HELD;
              press_q <= 1'b1;
            end
          end
          HELD: begin
            if (hit && state_q) begin
              st        <= IDLE;
              rep_cnt   <= '0;
              release_q <= 1'b1;
            end else if (bus.rep_period == '0) begin
              rep_cnt <= '0;
            end else if (rep_cnt >= rep_m1) begin
              rep_cnt  <= '0;
              press_q  <= 1'b1;
              repeat_q <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + CNT_W'(1);
            end
          end
          default: begin
            st      <= IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end

    assign key_state_v[i] = state_q;
    assign press_v[i]     = press_q;
    assign release_v[i]   = release_q;
    assign repeat_v[i]    = repeat_q;
  end

  // Pending is fed by the registered pulses, so a clear arriving with a
  // pulse loses to the set.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~bus.irq_clr)
                 | (press_v   & {NUM_KEYS{bus.evt_mode[0]}})
                 | (release_v & {NUM_KEYS{bus.evt_mode[1]}});
      irq_q     <= |(pending_q & bus.irq_mask);
    end
  end

  assign bus.key_state   = key_state_v;
  assign bus.key_press   = press_v;
  assign bus.key_release = release_v;
  assign bus.key_repeat  = repeat_v;
  assign bus.irq_pending = pending_q;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed scenarios plus randomized key bouncing, checked every cycle
// against a timestamp/run-length model of the debouncer.
module tb_key_debounce_array;
  localparam int N  = 4;
  localparam int CW = 12;

  logic HCLK;
  logic HRESET;
  int   total;
  int   bad;
  logic chk_on;
  logic [N-1:0] cv;

  key_debounce_if #(.NUM_KEYS(N), .CNT_W(CW)) bus ();

  key_debounce_array #(.NUM_KEYS(N), .CNT_W(CW)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus.slave)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Model: run = consecutive edges the synchronized level disagreed with the
  // debounced level; last = edge number of the last press/repeat.
  typedef struct packed {
    logic [N-1:0]        s1, s2, key, press, rel, rep, pend;
    logic                irq;
    logic [31:0]         cyc;
    logic [N-1:0][15:0]  run;
    logic [N-1:0][31:0]  last;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_step(input mdl_t s, input logic [N-1:0] col,
                                      input logic [CW-1:0] th, input logic [CW-1:0] rp,
                                      input logic [1:0] ev, input logic [N-1:0] msk,
                                      input logic [N-1:0] clr);
    mdl_t n;
    int   t;
    n = s;
    t = (th == 0) ? 1 : int'(th);
    n.cyc  = s.cyc + 1;
    n.irq  = |(s.pend & msk);
    n.pend = (s.pend & ~clr) | (s.press & {N{ev[0]}}) | (s.rel & {N{ev[1]}});
    n.press = '0;
    n.rel   = '0;
    n.rep   = '0;
    for (int i = 0; i < N; i++) begin
      if (s.s2[i] != s.key[i]) begin
        if (int'(s.run[i]) + 1 >= t) begin
          n.key[i] = ~s.key[i];
          n.run[i] = '0;
          if (n.key[i]) begin
            n.press[i] = 1'b1;
            n.last[i]  = n.cyc;
          end else begin
            n.rel[i] = 1'b1;
          end
        end else begin
          n.run[i] = s.run[i] + 16'd1;
        end
      end else begin
        n.run[i] = '0;
      end
      if (s.key[i] && n.key[i]) begin
        if (rp == 0) n.last[i] = n.cyc;
        else if (n.cyc - s.last[i] >= 32'(rp)) begin
          n.press[i] = 1'b1;
          n.rep[i]   = 1'b1;
          n.last[i]  = n.cyc;
        end
      end
    end
    n.s2 = s.s1;
    n.s1 = col;
    return n;
  endfunction

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) m <= '0;
    else m <= model_step(m, bus.col, bus.db_thresh, bus.rep_period,
                         bus.evt_mode, bus.irq_mask, bus.irq_clr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_on) begin
      chk("cmp_key_state",   32'(bus.key_state),   32'(m.key));
      chk("cmp_key_press",   32'(bus.key_press),   32'(m.press));
      chk("cmp_key_release", 32'(bus.key_release), 32'(m.rel));
      chk("cmp_key_repeat",  32'(bus.key_repeat),  32'(m.rep));
      chk("cmp_irq_pending", 32'(bus.irq_pending), 32'(m.pend));
      chk("cmp_irq",         32'(bus.irq),         32'(m.irq));
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  int np, nr, gap_bad, first_k, last_k;

  initial begin
    total = 0;
    bad = 0;
    chk_on = 1'b0;
    HRESET = 1'b0;
    bus.col = '0;
    bus.db_thresh = CW'(4);
    bus.rep_period = '0;
    bus.evt_mode = 2'b01;
    bus.irq_mask = 4'b0001;
    bus.irq_clr = '0;
    #1 HRESET = 1'b1;
    #1 chk_on = 1'b1;
    step();
    step();
    chk("reset_key_state", 32'(bus.key_state), 0);
    chk("reset_irq", 32'(bus.irq), 0);
    HRESET = 1'b0;

    // Press on ch0 with T=4
    bus.col = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) chk("press_e5_state", 32'(bus.key_state[0]), 0);
      if (k == 6) begin
        chk("press_e6_state", 32'(bus.key_state[0]), 1);
        chk("press_e6_pulse", 32'(bus.key_press[0]), 1);
        chk("model_press_e6", 32'(m.press[0]), 1);
      end
      if (k == 7) begin
        chk("press_e7_pulse", 32'(bus.key_press[0]), 0);
        chk("press_e7_pend", 32'(bus.irq_pending[0]), 1);
        chk("press_e7_irq", 32'(bus.irq), 0);
      end
      if (k == 8) chk("press_e8_irq", 32'(bus.irq), 1);
    end

    // Short glitch on ch1
    bus.col = 4'b0011;
    repeat (3) step();
    bus.col = 4'b0001;
    repeat (10) step();
    chk("glitch_state", 32'(bus.key_state), 32'h1);
    chk("glitch_pend", 32'(bus.irq_pending), 32'h1);

    // Auto-repeat on held ch0
    bus.rep_period = CW'(10);
    np = 0; nr = 0; gap_bad = 0; first_k = -1; last_k = -1;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (bus.key_press[0]) begin
        np++;
        if (bus.key_repeat[0]) nr++;
        if (first_k < 0) first_k = k;
        if (last_k >= 0 && k - last_k != 10) gap_bad++;
        last_k = k;
      end
    end
    chk("rep_count", 32'(np), 5);
    chk("rep_flag_count", 32'(nr), 5);
    chk("rep_first", 32'(first_k), 10);
    chk("rep_gap_bad", 32'(gap_bad), 0);
    bus.col = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 6) begin
        chk("rel_pulse", 32'(bus.key_release[0]), 1);
        chk("rel_state", 32'(bus.key_state[0]), 0);
      end
    end
    np = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (bus.key_press[0]) np++;
    end
    chk("no_rep_after_rel", 32'(np), 0);
    bus.rep_period = '0;

    // Clear colliding with a press on ch2
    bus.col = 4'b0100;
    repeat (6) step();
    chk("clr_press_pulse", 32'(bus.key_press[2]), 1);
    bus.irq_clr = 4'b0100;
    step();
    chk("clr_collide_pend", 32'(bus.irq_pending[2]), 1);
    step();
    chk("clr_alone_pend", 32'(bus.irq_pending[2]), 0);
    bus.irq_clr = '0;

    // Async reset mid-debounce, T=8
    bus.db_thresh = CW'(8);
    bus.col = 4'b1100;
    repeat (5) step();
    #2 HRESET = 1'b1;
    #1;
    chk("async_rst_state", 32'(bus.key_state), 0);
    chk("async_rst_pend", 32'(bus.irq_pending), 0);
    chk("async_rst_irq", 32'(bus.irq), 0);
    chk("model_rst_key", 32'(m.key), 0);
    step();
    step();
    HRESET = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) chk("rst_e9_state", 32'(bus.key_state[3]), 0);
      if (k == 10) begin
        chk("rst_e10_state", 32'(bus.key_state[3]), 1);
        chk("rst_e10_press", 32'(bus.key_press[3]), 1);
      end
    end

    // Zero threshold, then lowered threshold mid-count
    bus.db_thresh = '0;
    bus.col = 4'b1110;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 2) chk("t0_e2_state", 32'(bus.key_state[1]), 0);
      if (k == 3) chk("t0_e3_state", 32'(bus.key_state[1]), 1);
    end
    bus.db_thresh = CW'(100);
    bus.col = 4'b1100;
    repeat (42) step();
    chk("lower_before", 32'(bus.key_state[1]), 1);
    bus.db_thresh = CW'(5);
    step();
    chk("lower_after_state", 32'(bus.key_state[1]), 0);
    chk("lower_after_rel", 32'(bus.key_release[1]), 1);

    // Randomized bouncing with occasional reconfiguration and resets
    bus.irq_mask = 4'b1111;
    bus.evt_mode = 2'b11;
    bus.db_thresh = CW'(3);
    bus.rep_period = CW'(5);
    for (int c = 0; c < 4000; c++) begin
      cv = bus.col;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) cv[i] = ~cv[i];
      bus.col = cv;
      if ($urandom_range(0, 199) == 0) begin
        bus.db_thresh  = CW'($urandom_range(0, 6));
        bus.rep_period = CW'($urandom_range(0, 9));
        bus.evt_mode   = 2'($urandom);
        bus.irq_mask   = 4'($urandom);
      end
      bus.irq_clr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 1499) == 0) HRESET = 1'b1;
      step();
      HRESET = 1'b0;
    end
    bus.irq_clr = '0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of independent key channels, range 1..32.
REQ-002 Parameter CNT_W, default 12: width of the debounce and repeat counters and their threshold inputs, range 2..16.
REQ-003 Port HCLK, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port HRESET, input, 1: reset, asynchronous and active-high.
REQ-005 Port col, input, NUM_KEYS: raw asynchronous key levels; 1 = pressed.
REQ-006 Port db_thresh, input, CNT_W: debounce length in cycles; quasi-static.
REQ-007 Port rep_period, input, CNT_W: auto-repeat period in cycles; 0 disables repeat.
REQ-008 Port evt_mode, input, 2: bit0 enables press events into pending; bit1 enables release events into pending.
REQ-009 Port irq_mask, input, NUM_KEYS: per-channel interrupt enable.
REQ-010 Port irq_clr, input, NUM_KEYS: per-channel pending-clear pulse, one cycle.
REQ-011 Port key_state, output, NUM_KEYS: debounced level, registered.
REQ-012 Port key_press, output, NUM_KEYS: one-cycle pulse on a debounced press or an auto-repeat.
REQ-013 Port key_release, output, NUM_KEYS: one-cycle pulse on a debounced release.
REQ-014 Port key_repeat, output, NUM_KEYS: qualifies key_press; high only when the pulse is a repeat.
REQ-015 Port irq_pending, output, NUM_KEYS: sticky event flags.
REQ-016 Port irq, output, 1: OR over (irq_pending AND irq_mask), registered.

Function
REQ-017 Each col bit SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-018 The effective threshold SHALL be T = max(db_thresh, 1).
REQ-019 Per channel, when sync equals key_state, the debounce counter SHALL clear to 0.
REQ-020 When sync differs from key_state and counter >= T-1, key_state SHALL toggle and the counter SHALL clear; otherwise the counter SHALL increment. The >= comparison covers a lowered db_thresh, and the counter never wraps.
REQ-021 Latency: for col held stable from before edge 1, key_state SHALL change after edge T+2; any disagreement shorter than T cycles at sync SHALL produce no change.
REQ-022 key_press/key_release SHALL be high exactly in the cycle following the toggle edge, i.e. the first cycle of the new key_state.
REQ-023 Repeat FSM per channel, states IDLE and HELD. IDLE->HELD on debounced press; HELD->IDLE on debounced release.
REQ-024 In HELD with rep_period != 0, the repeat counter SHALL increment each cycle. On reaching rep_period it SHALL clear and pulse key_press and key_repeat together for one cycle.
REQ-025 The repeat counter SHALL clear on entry to HELD, on exit from HELD, and while rep_period == 0.
REQ-026 irq_pending[i] SHALL set on a press pulse (including repeats) if evt_mode[0] = 1, and on a release pulse if evt_mode[1] = 1.
REQ-027 irq_pending[i] SHALL clear on irq_clr[i]. A set and a clear in the same cycle SHALL leave it set.
REQ-028 irq SHALL reflect irq_pending and irq_mask with one cycle of register latency.
REQ-029 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported in the same cycle.

Reset
REQ-030 While HRESET = 1, the following SHALL be 0 immediately and asynchronously: synchronizers, counters, key_state, key_press, key_release, key_repeat, irq_pending and irq; the FSM SHALL be in IDLE.
REQ-031 Reset asserted mid-debounce or in HELD SHALL discard the in-progress count with no event pulses.
REQ-032 After deassertion, a col already high SHALL debounce afresh and produce a press after T+2 edges.

Verification
REQ-033 db_thresh=4, col[0] 0->1 held -> key_state[0]=1 after edge 6; key_press[0] one cycle; pending[0]=1 with evt_mode=01; irq=1 one cycle later when irq_mask[0]=1.
REQ-034 db_thresh=4, col[1] high for 3 cycles then low -> no pulses, key_state[1] stays 0, pending unchanged.
REQ-035 rep_period=10, key held 50 cycles after debounce -> 5 key_press pulses with key_repeat=1, 10 cycles apart; release -> key_release pulse, no further repeats.
REQ-036 irq_clr[2] asserted in the same cycle as a new press pulse on ch2 -> irq_pending[2] remains 1; a clr on the next cycle alone -> 0.
REQ-037 HRESET asserted at count 3 of 8 -> all outputs 0 asynchronously; release with col high -> press after edge 10.
REQ-038 db_thresh=0 -> behaves as T=1 (press after edge 3). Lowering db_thresh from 100 to 5 mid-count at count 40 -> toggle on the next edge.
